// File: rtl/imm_seq_pkg.sv
// Shared types and constants for the immediate-instruction control sequencer:
// state encoding, opcode values and the decoder output bundle.
package imm_seq_pkg;

    // T0..T5 encode directly as their T-step number
    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_HALT = 3'd6,
        S_IDLE = 3'd7
    } state_t;

    localparam logic [4:0] OP_LDI  = 5'd17;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;

    localparam logic [2:0] TSTEP_IDLE = 3'd7;

    typedef struct packed {
        logic grb;
        logic ba_out;
        logic rout;
        logic yin;
        logic alu_add;
        logic alu_and;
        logic alu_or;
        logic legal;
    } op_dec_t;

endpackage

// File: rtl/imm_op_decoder.sv
// Combinational opcode decoder: operand-fetch strobe set, ALU select and
// legality for the immediate instruction group.
module imm_op_decoder
    import imm_seq_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output op_dec_t        dec
);

    always_comb begin
        dec = '0;
        if (opcode == OPW'(OP_LDI)) begin
            dec.grb     = 1'b1;
            dec.ba_out  = 1'b1;
            dec.yin     = 1'b1;
            dec.alu_add = 1'b1;
            dec.legal   = 1'b1;
        end else if (opcode == OPW'(OP_ADDI)) begin
            dec.grb     = 1'b1;
            dec.rout    = 1'b1;
            dec.yin     = 1'b1;
            dec.alu_add = 1'b1;
            dec.legal   = 1'b1;
        end else if (opcode == OPW'(OP_ANDI)) begin
            dec.grb     = 1'b1;
            dec.rout    = 1'b1;
            dec.yin     = 1'b1;
            dec.alu_and = 1'b1;
            dec.legal   = 1'b1;
        end else if (opcode == OPW'(OP_ORI)) begin
            dec.grb     = 1'b1;
            dec.rout    = 1'b1;
            dec.yin     = 1'b1;
            dec.alu_or  = 1'b1;
            dec.legal   = 1'b1;
        end
    end

endmodule

// File: rtl/imm_control_sequencer.sv
// T-step control sequencer for LDI/ADDI/ANDI/ORI.
// Optional IMM_SEQ_SINGLE_STEP_EN adds a step input that gates every state advance.
module imm_control_sequencer
    import imm_seq_pkg::*;
#(
    parameter int OPW      = 5,
    parameter int MEM_WAIT = 0,
    parameter int AUTO_RUN = 0
) (
    input  logic           clock,
    input  logic           clear_n,
`ifdef IMM_SEQ_SINGLE_STEP_EN
    input  logic           step,
`endif
    input  logic           run,
    input  logic [OPW-1:0] ir_opcode,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zlowin,
    output logic           Zlowout,
    output logic           PCin,
    output logic           MDMuxread,
    output logic           RAMread,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Grb,
    output logic           Gra,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Yin,
    output logic           CSEout,
    output logic           ADD,
    output logic           AND,
    output logic           OR,
    output logic [2:0]     tstep,
    output logic           busy,
    output logic           done,
    output logic           illegal
);

    localparam logic       AUTO_ON   = (AUTO_RUN != 0);
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [2:0]     wait_cnt;
    logic           sync_q1;
    logic           rst_sync_n;
    logic           advance;
    logic [OPW-1:0] dec_op;
    op_dec_t        dec;

`ifdef IMM_SEQ_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // Assertion passes straight through; release is delayed by two edges
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_q1    <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            sync_q1    <= 1'b1;
            rst_sync_n <= sync_q1;
        end
    end

    // One decoder serves T3 (live IR field) and T4 (latched opcode)
    assign dec_op = (state == S_T4) ? op_q : ir_opcode;

    imm_op_decoder #(.OPW(OPW)) u_dec (
        .opcode (dec_op),
        .dec    (dec)
    );

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else if (advance) begin
            case (state)
                S_IDLE: if (run || AUTO_ON) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_T2;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_T2:   state <= S_T3;
                S_T3: begin
                    op_q <= ir_opcode;
                    if (dec.legal) begin
                        state <= S_T4;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                S_T4:   state <= S_T5;
                S_T5:   state <= (run || AUTO_ON) ? S_T0 : S_IDLE;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread,
         MDRin, MDRout, IRin, Grb, Gra, Rin, Rout, BAout, Yin, CSEout,
         ADD, AND, OR} = '0;
        case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                MDMuxread = 1'b1;
                RAMread   = 1'b1;
                MDRin     = 1'b1;
                if (wait_cnt == '0) begin
                    PCin    = 1'b1;
                    Zlowout = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Grb   = dec.grb;
                BAout = dec.ba_out;
                Rout  = dec.rout;
                Yin   = dec.yin;
            end
            S_T4: begin
                CSEout = 1'b1;
                Zlowin = 1'b1;
                ADD    = dec.alu_add;
                AND    = dec.alu_and;
                OR     = dec.alu_or;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign tstep = (state == S_IDLE || state == S_HALT) ? TSTEP_IDLE : 3'(state);
    assign busy  = (state != S_IDLE) && (state != S_HALT);
    assign done  = (state == S_T5);

endmodule

// File: tb/tb_imm_control_sequencer.sv
// Directed self-checking bench for imm_control_sequencer (MEM_WAIT=0 and MEM_WAIT=3 instances).
module tb_imm_control_sequencer;

    localparam int B_PCOUT = 20, B_MARIN = 19, B_INCPC = 18, B_ZLOWIN = 17,
                   B_ZLOWOUT = 16, B_PCIN = 15, B_MDMUX = 14, B_RAMRD = 13,
                   B_MDRIN = 12, B_MDROUT = 11, B_IRIN = 10, B_GRB = 9, B_GRA = 8,
                   B_RIN = 7, B_ROUT = 6, B_BAOUT = 5, B_YIN = 4, B_CSE = 3,
                   B_ADD = 2, B_AND = 1, B_OR = 0;

    localparam logic [4:0] LDI = 5'd17, ADDI = 5'd12, ANDI = 5'd13, ORI = 5'd14, BAD = 5'd31;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        run;
    logic [4:0]  op;
`ifdef IMM_SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic [20:0] str_a, str_b;
    logic [2:0]  ts_a, ts_b;
    logic        busy_a, busy_b, done_a, done_b, ill_a, ill_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    imm_control_sequencer #(.OPW(5), .MEM_WAIT(0), .AUTO_RUN(0)) u_dut_a (
        .clock(clock), .clear_n(clear_n),
`ifdef IMM_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .run(run), .ir_opcode(op),
        .PCout(str_a[B_PCOUT]), .MARin(str_a[B_MARIN]), .IncPC(str_a[B_INCPC]),
        .Zlowin(str_a[B_ZLOWIN]), .Zlowout(str_a[B_ZLOWOUT]), .PCin(str_a[B_PCIN]),
        .MDMuxread(str_a[B_MDMUX]), .RAMread(str_a[B_RAMRD]), .MDRin(str_a[B_MDRIN]),
        .MDRout(str_a[B_MDROUT]), .IRin(str_a[B_IRIN]), .Grb(str_a[B_GRB]),
        .Gra(str_a[B_GRA]), .Rin(str_a[B_RIN]), .Rout(str_a[B_ROUT]),
        .BAout(str_a[B_BAOUT]), .Yin(str_a[B_YIN]), .CSEout(str_a[B_CSE]),
        .ADD(str_a[B_ADD]), .AND(str_a[B_AND]), .OR(str_a[B_OR]),
        .tstep(ts_a), .busy(busy_a), .done(done_a), .illegal(ill_a)
    );

    imm_control_sequencer #(.OPW(5), .MEM_WAIT(3), .AUTO_RUN(0)) u_dut_b (
        .clock(clock), .clear_n(clear_n),
`ifdef IMM_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .run(run), .ir_opcode(op),
        .PCout(str_b[B_PCOUT]), .MARin(str_b[B_MARIN]), .IncPC(str_b[B_INCPC]),
        .Zlowin(str_b[B_ZLOWIN]), .Zlowout(str_b[B_ZLOWOUT]), .PCin(str_b[B_PCIN]),
        .MDMuxread(str_b[B_MDMUX]), .RAMread(str_b[B_RAMRD]), .MDRin(str_b[B_MDRIN]),
        .MDRout(str_b[B_MDROUT]), .IRin(str_b[B_IRIN]), .Grb(str_b[B_GRB]),
        .Gra(str_b[B_GRA]), .Rin(str_b[B_RIN]), .Rout(str_b[B_ROUT]),
        .BAout(str_b[B_BAOUT]), .Yin(str_b[B_YIN]), .CSEout(str_b[B_CSE]),
        .ADD(str_b[B_ADD]), .AND(str_b[B_AND]), .OR(str_b[B_OR]),
        .tstep(ts_b), .busy(busy_b), .done(done_b), .illegal(ill_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected strobe vector for a T-step (7 = IDLE/HALT), built from the strobe table
    function automatic logic [20:0] exp_vec(input int t, input logic [4:0] opc, input bit first);
        logic [20:0] v;
        v = '0;
        case (t)
            0: begin v[B_PCOUT] = 1; v[B_MARIN] = 1; v[B_INCPC] = 1; v[B_ZLOWIN] = 1; end
            1: begin
                v[B_MDMUX] = 1; v[B_RAMRD] = 1; v[B_MDRIN] = 1;
                if (first) begin v[B_PCIN] = 1; v[B_ZLOWOUT] = 1; end
            end
            2: begin v[B_MDROUT] = 1; v[B_IRIN] = 1; end
            3: begin
                if (opc == LDI) begin v[B_GRB] = 1; v[B_BAOUT] = 1; v[B_YIN] = 1; end
                else if (opc == ADDI || opc == ANDI || opc == ORI) begin
                    v[B_GRB] = 1; v[B_ROUT] = 1; v[B_YIN] = 1;
                end
            end
            4: begin
                v[B_CSE] = 1; v[B_ZLOWIN] = 1;
                if (opc == LDI || opc == ADDI) v[B_ADD] = 1;
                else if (opc == ANDI) v[B_AND] = 1;
                else if (opc == ORI) v[B_OR] = 1;
            end
            5: begin v[B_ZLOWOUT] = 1; v[B_GRA] = 1; v[B_RIN] = 1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic check_cycle(input int sel, input string tag, input int t,
                               input logic [4:0] opc, input bit first);
        logic [20:0] s;
        logic [2:0]  ts;
        logic        b, d;
        string       tg;
        if (sel == 0) begin s = str_a; ts = ts_a; b = busy_a; d = done_a; end
        else          begin s = str_b; ts = ts_b; b = busy_b; d = done_b; end
        tg = $sformatf("%s_t%0d", tag, t);
        check({tg, "/strobes"}, 32'(s), 32'(exp_vec(t, opc, first)));
        check({tg, "/tstep"}, 32'(ts), 32'(t));
        check({tg, "/busy"}, 32'(b), (t <= 5) ? 32'd1 : 32'd0);
        check({tg, "/done"}, 32'(d), (t == 5) ? 32'd1 : 32'd0);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Pulse clear_n for one cycle, then wait out the two-flop release so the next edge can start T0
    task automatic reset_and_sync;
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        tick();
        tick();
    endtask

    // Walk one instruction from T0 to T5; op switches to nxt once T4 is entered
    task automatic walk(input int sel, input string tag, input logic [4:0] opc,
                        input int waits, input bit drop_run, input logic [4:0] nxt);
        op = opc;
        check_cycle(sel, tag, 0, opc, 1'b0);
        if (drop_run) run = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            tick();
            check_cycle(sel, tag, 1, opc, w == 0);
        end
        for (int t = 2; t <= 5; t++) begin
            tick();
            if (t == 4) op = nxt;
            check_cycle(sel, tag, t, opc, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_n = 1'b0;
        run     = 1'b0;
        op      = '0;
`ifdef IMM_SEQ_SINGLE_STEP_EN
        step    = 1'b1;
`endif
        tick();
        check_cycle(0, "reset", 7, '0, 1'b0);
        check("reset/illegal", 32'(ill_a), 32'd0);

        // LDI single instruction; release needs two edges before T0
        run = 1'b1;
        op  = LDI;
        clear_n = 1'b1;
        tick();
        check_cycle(0, "rel1", 7, LDI, 1'b0);
        tick();
        check_cycle(0, "rel2", 7, LDI, 1'b0);
        tick();
        walk(0, "ldi", LDI, 0, 1'b1, LDI);
        tick();
        check_cycle(0, "ldi_end", 7, LDI, 1'b0);

        // ANDI then ORI back-to-back; T4 must follow the latched opcode
        run = 1'b1;
        reset_and_sync();
        tick();
        walk(0, "andi", ANDI, 0, 1'b0, ORI);
        tick();
        walk(0, "ori", ORI, 0, 1'b1, BAD);
        tick();
        check_cycle(0, "b2b_end", 7, ORI, 1'b0);

        // MEM_WAIT=3 ADDI on the second instance
        run = 1'b1;
        op  = ADDI;
        reset_and_sync();
        tick();
        walk(1, "addi_w3", ADDI, 3, 1'b1, ADDI);
        tick();
        check_cycle(1, "addi_w3_end", 7, ADDI, 1'b0);

        // Illegal opcode halts until clear_n
        run = 1'b1;
        op  = BAD;
        reset_and_sync();
        tick();
        check_cycle(0, "ill", 0, BAD, 1'b0);
        tick();
        check_cycle(0, "ill", 1, BAD, 1'b1);
        tick();
        check_cycle(0, "ill", 2, BAD, 1'b0);
        tick();
        check_cycle(0, "ill", 3, BAD, 1'b0);
        check("ill_t3/illegal", 32'(ill_a), 32'd0);
        tick();
        check_cycle(0, "halt", 7, BAD, 1'b0);
        check("halt/illegal", 32'(ill_a), 32'd1);
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            tick();
            check_cycle(0, $sformatf("halt%0d", i), 7, BAD, 1'b0);
            check($sformatf("halt%0d/illegal", i), 32'(ill_a), 32'd1);
        end
        clear_n = 1'b0;
        #1;
        check("halt_clr/illegal", 32'(ill_a), 32'd0);
        check_cycle(0, "halt_clr", 7, BAD, 1'b0);
        clear_n = 1'b1;

        // Asynchronous clear in the middle of T4
        run = 1'b1;
        op  = LDI;
        reset_and_sync();
        tick();
        check_cycle(0, "mid", 0, LDI, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            tick();
            check_cycle(0, "mid", t, LDI, t == 1);
        end
        #3;
        clear_n = 1'b0;
        #1;
        check_cycle(0, "async_clr", 7, LDI, 1'b0);
        check("async_clr/illegal", 32'(ill_a), 32'd0);
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        tick();
        check_cycle(0, "post_rel1", 7, LDI, 1'b0);
        tick();
        check_cycle(0, "post_rel2", 7, LDI, 1'b0);
        tick();
        check_cycle(0, "post_clr", 0, LDI, 1'b0);
        tick();
        check_cycle(0, "post_clr", 1, LDI, 1'b1);

`ifdef IMM_SEQ_SINGLE_STEP_EN
        // One state advance per step pulse, everything frozen in between
        run = 1'b1;
        op  = LDI;
        step = 1'b0;
        reset_and_sync();
        check_cycle(0, "step_idle", 7, LDI, 1'b0);
        for (int t = 0; t <= 5; t++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check_cycle(0, "step", t, LDI, t == 1);
            for (int k = 0; k < 3; k++) begin
                tick();
                check_cycle(0, $sformatf("step_hold%0d", k), t, LDI, t == 1);
            end
        end
        step = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_control_sequencer.md
IMM_CONTROL_SEQUENCER -- requirements
Module: imm_control_sequencer

Interface
REQ-001 Parameter OPW, default 5: opcode width, taken from IR[31:32-OPW].
REQ-002 Parameter MEM_WAIT, default 0, range 0..7: extra T1 cycles for RAM read latency.
REQ-003 Parameter AUTO_RUN, default 0: if 1, the block leaves IDLE without sampling run.
REQ-004 There SHALL be one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clock  in  1  rising-edge clock
- clear_n  in  1  async active-low reset
- run  in  1  level; fetch next instruction while high
- ir_opcode  in  OPW  opcode field from IR
- PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread, MDRin, MDRout, IRin  out  1 each  datapath strobes
- Grb, Gra, Rin, Rout, BAout, Yin, CSEout  out  1 each  register-file and immediate strobes
- ADD, AND, OR  out  1 each  ALU select
- tstep  out  3  current T-step (0..5; 7 in IDLE or HALT)
- busy  out  1  high in T0..T5
- done  out  1  one-cycle pulse during T5
- illegal  out  1  sticky illegal-opcode flag

Function
REQ-006 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALT; all outputs are Moore outputs decoded from the state register plus the latched opcode op_q.
REQ-007 IDLE -> T0 when run=1 (or AUTO_RUN=1); otherwise stay.
REQ-008 T0 SHALL assert PCout, MARin, IncPC, Zlowin; T0 -> T1.
REQ-009 T1 SHALL assert Zlowout, PCin, MDMuxread, RAMread, MDRin; hold for MEM_WAIT+1 cycles via wait counter; PCin and Zlowout assert only in the first T1 cycle, RAMread/MDMuxread/MDRin in all T1 cycles.
REQ-010 T2 SHALL assert MDRout, IRin; T2 -> T3.
REQ-011 In T3, ir_opcode is decoded: LDI -> Grb, BAout, Yin; ADDI/ANDI/ORI -> Grb, Rout, Yin; op_q loads ir_opcode at exit of T3.
REQ-012 Illegal opcode in T3: no T3 strobes, illegal set, T3 -> HALT.
REQ-013 T4 SHALL assert CSEout, Zlowin and one of ADD (LDI, ADDI), AND (ANDI), OR (ORI).
REQ-014 T5 SHALL assert Zlowout, Gra, Rin, done; T5 -> T0 if run=1 (or AUTO_RUN), else IDLE.
REQ-015 run deasserted during T0..T4 SHALL NOT abort; the instruction completes, then IDLE.
REQ-016 HALT SHALL drive all strobes 0 and remain until clear_n is asserted; run is ignored.
REQ-017 Instruction latency SHALL be 6+MEM_WAIT cycles; back-to-back instructions have zero idle cycles.
REQ-018 At most one ALU select SHALL be high in any cycle.

Reset
REQ-019 clear_n=0 SHALL immediately force IDLE, all strobes 0, busy=0, done=0, illegal=0, tstep=7, op_q=0, wait counter=0, including mid-instruction.
REQ-020 Deassertion is synchronised internally by a two-flop release; the first T0 is no earlier than the third rising edge after release.

Configuration
REQ-021 Macro IMM_SEQ_SINGLE_STEP_EN: defined -> extra input step (1 bit); the FSM advances one state only on a cycle with step=1 and otherwise holds state and strobes (T1 wait counting also gated); undefined -> no step port, free-running.

Structure
REQ-022 Package imm_seq_pkg SHALL hold the state enum, opcode constants (LDI=5'd17, ADDI=5'd12, ANDI=5'd13, ORI=5'd14) and the IDLE tstep code 3'd7.
REQ-023 Sub-module imm_op_decoder (combinational: opcode -> T3 strobe set, ALU select, legal flag) SHALL be used for both the T3 and T4 decode.

Verification
REQ-024 Reset, run=1, opcode LDI, MEM_WAIT=0 -> T0..T5 in 6 cycles; T3 has BAout=1, Rout=0; T4 has ADD=1; done pulses once.
REQ-025 ANDI (5'd13) then ORI (5'd14) back-to-back, run held -> 12 cycles, T4 selects AND, then OR; T0 of the second instruction directly follows T5.
REQ-026 MEM_WAIT=3, ADDI -> T1 lasts 4 cycles, PCin high only in the first; total 9 cycles.
REQ-027 Opcode 5'd31 at T3 -> no T3 strobes, illegal=1, HALT; run toggling -> no strobes until clear_n pulse, then illegal=0.
REQ-028 clear_n low during T4 -> all outputs 0 asynchronously, tstep=7; after release and run=1, a clean T0.
REQ-029 IMM_SEQ_SINGLE_STEP_EN defined, step pulsed every 4th cycle -> one state advance per pulse; strobes stable between pulses.
